// File: rtl/spi_xfer_ctrl_if.sv
// Bundle of the command, TX/RX stream, Wishbone master and status signals of spi_xfer_ctrl.
// master is the controller's view; slave is the view of the logic around it.
interface spi_xfer_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_div;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;

    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_we_o;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;

    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  cmd_valid, cmd_len, cmd_mode, cmd_div,
        input  tx_valid, tx_data, rx_ready,
        input  wb_dat_i, wb_ack_i,
        output cmd_ready, tx_ready, rx_valid, rx_data,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        output busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_mode, cmd_div,
        output tx_valid, tx_data, rx_ready,
        output wb_dat_i, wb_ack_i,
        input  cmd_ready, tx_ready, rx_valid, rx_data,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        input  busy, done, err
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Wishbone master sequencing a simple_spi core through one configured burst of 1..256 bytes.
// Define SPI_XFER_CTRL_TIMEOUT_EN to add the ack watchdog, the SPSR poll limit and the abort path.
module spi_xfer_ctrl
`ifdef SPI_XFER_CTRL_TIMEOUT_EN
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int POLL_LIMIT  = 4096
)
`endif
(
    input  logic          clk_i,
    input  logic          rst_i,
    spi_xfer_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_CR,
        S_CFG_ER,
        S_SS_ON,
        S_TX_WAIT,
        S_WR_DR,
        S_POLL,
        S_RD_DR,
        S_CLR_IF,
        S_RX_PUSH,
        S_SS_OFF,
        S_DONE,
        S_ABORT,
        S_ABORT_SS
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] div_q, div_d;
    logic [7:0] txb_q, txb_d;
    logic [7:0] rxd_q, rxd_d;
    logic       cyc_q, cyc_d;
    logic       we_q, we_d;
    logic [2:0] adr_q, adr_d;
    logic [7:0] wdat_q, wdat_d;

    logic       acc_en;
    logic       acc_we;
    logic [2:0] acc_adr;
    logic [7:0] acc_dat;
    logic       acked;

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
    localparam int WD_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic              wd_expired;
    logic              poll_expired;
`endif

    assign acked = cyc_q & bus.wb_ack_i;

    // Register access each bus-owning state performs; launched only from an idle bus.
    always_comb begin
        acc_en  = 1'b0;
        acc_we  = 1'b0;
        acc_adr = 3'd0;
        acc_dat = 8'h00;
        case (state_q)
            S_CFG_CR:   begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd0;
                              acc_dat = {4'b0101, mode_q, div_q[1:0]}; end
            S_CFG_ER:   begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd3;
                              acc_dat = {6'b000000, div_q[3:2]}; end
            S_SS_ON:    begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd4; acc_dat = 8'h01; end
            S_WR_DR:    begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd2; acc_dat = txb_q; end
            S_POLL:     begin acc_en = 1'b1; acc_adr = 3'd1; end
            S_RD_DR:    begin acc_en = 1'b1; acc_adr = 3'd2; end
            S_CLR_IF:   begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd1; acc_dat = 8'h80; end
            S_SS_OFF,
            S_ABORT_SS: begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = 3'd4; acc_dat = 8'h00; end
            default:    ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        div_d   = div_q;
        txb_d   = txb_q;
        rxd_d   = rxd_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;

        if (acc_en && !cyc_q) begin
            cyc_d  = 1'b1;
            we_d   = acc_we;
            adr_d  = acc_adr;
            wdat_d = acc_dat;
        end else if (acked) begin
            cyc_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cnt_d   = bus.cmd_len;
                    mode_d  = bus.cmd_mode;
                    div_d   = bus.cmd_div;
                    state_d = S_CFG_CR;
                end
            end
            S_CFG_CR:  if (acked) state_d = S_CFG_ER;
            S_CFG_ER:  if (acked) state_d = S_SS_ON;
            S_SS_ON:   if (acked) state_d = S_TX_WAIT;
            S_TX_WAIT: begin
                if (bus.tx_valid) begin
                    txb_d   = bus.tx_data;
                    state_d = S_WR_DR;
                end
            end
            S_WR_DR:   if (acked) state_d = S_POLL;
            S_POLL:    if (acked && !bus.wb_dat_i[0]) state_d = S_RD_DR;
            S_RD_DR: begin
                if (acked) begin
                    rxd_d   = bus.wb_dat_i;
                    state_d = S_CLR_IF;
                end
            end
            S_CLR_IF:  if (acked) state_d = S_RX_PUSH;
            // The counter only moves once the consumer has taken the byte, so a stall loses nothing.
            S_RX_PUSH: begin
                if (bus.rx_ready) begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_SS_OFF;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        state_d = S_TX_WAIT;
                    end
                end
            end
            S_SS_OFF:   if (acked) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            S_ABORT:    state_d = S_ABORT_SS;
            S_ABORT_SS: if (acked) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
        wd_d   = (cyc_q && !bus.wb_ack_i) ? wd_q + WD_W'(1) : '0;
        poll_d = (state_q != S_POLL) ? '0 :
                 (acked && bus.wb_dat_i[0]) ? poll_q + POLL_W'(1) : poll_q;
        // The cleanup SSCR write is best effort and never aborts itself.
        if (state_q != S_ABORT_SS && (wd_expired || poll_expired)) begin
            cyc_d   = 1'b0;
            wd_d    = '0;
            poll_d  = '0;
            state_d = S_ABORT;
        end
`endif
    end

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
    assign wd_expired   = cyc_q && !bus.wb_ack_i && (wd_q == WD_W'(ACK_TIMEOUT - 1));
    assign poll_expired = (state_q == S_POLL) && acked && bus.wb_dat_i[0] &&
                          (poll_q == POLL_W'(POLL_LIMIT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q   <= '0;
            poll_q <= '0;
        end else begin
            wd_q   <= wd_d;
            poll_q <= poll_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            mode_q  <= 2'd0;
            div_q   <= 4'd0;
            txb_q   <= 8'h00;
            rxd_q   <= 8'h00;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 3'd0;
            wdat_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            txb_q   <= txb_d;
            rxd_q   <= rxd_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.tx_ready  = (state_q == S_TX_WAIT) && bus.tx_valid;
    assign bus.rx_valid  = (state_q == S_RX_PUSH);
    assign bus.rx_data   = rxd_q;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = cyc_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_dat_o  = wdat_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
`ifdef SPI_XFER_CTRL_TIMEOUT_EN
    assign bus.err       = (state_q == S_ABORT);
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: table of bursts against a loopback simple_spi register model,
// plus hand-written reset-in-POLL and (SPI_XFER_CTRL_TIMEOUT_EN only) ack-timeout sequences.
module tb_spi_xfer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_xfer_ctrl_if bus();

    spi_xfer_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] len;
        logic [1:0] mode;
        logic [3:0] div;
        logic [7:0] base;
        int         stall;
        logic [7:0] exp_spcr;
        logic [7:0] exp_sper;
    } vec_t;

    vec_t vecs [5];

    int n_cmp = 0;
    int n_fail = 0;

    logic [10:0] wr_log [$];
    logic [7:0]  rx_q   [$];
    logic [7:0]  fifo   [$];
    int          spdr_writes = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          overlap_bad = 0;
    int          cyc_n = 0;
    int          err_t = 0;
    int          sson_t = -1;
    bit          stop_feed = 1'b0;
    bit          suppress_once = 1'b0;
    bit          sup_seen = 1'b0;
    logic        spif = 1'b0;
    logic [7:0]  pend_byte = 8'h00;
    int          pend_cnt = 0;

    function automatic int ent(input int adr, input int dat);
        return adr * 256 + dat;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Loopback simple_spi model: SPDR writes reappear in the RX FIFO a few cycles later, so
    // RFEMPTY reads 1 for the first poll(s) of each byte.
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = 8'h00;
            fifo.delete();
            spif = 1'b0;
            pend_cnt = 0;
        end else begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    fifo.push_back(pend_byte);
                    spif = 1'b1;
                end
            end
            if (bus.wb_ack_i) begin
                bus.wb_ack_i = 1'b0;
            end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
                if (suppress_once && bus.wb_adr_o == 3'd4) begin
                    sup_seen = 1'b1;
                end else begin
                    bus.wb_ack_i = 1'b1;
                    if (bus.wb_we_o) begin
                        wr_log.push_back({bus.wb_adr_o, bus.wb_dat_o});
                        if (bus.wb_adr_o == 3'd2) begin
                            spdr_writes++;
                            pend_byte = bus.wb_dat_o;
                            pend_cnt = 3;
                        end else if (bus.wb_adr_o == 3'd1 && bus.wb_dat_o[7]) begin
                            spif = 1'b0;
                        end
                    end else if (bus.wb_adr_o == 3'd1) begin
                        bus.wb_dat_i = {spif, 6'b000000, (fifo.size() == 0)};
                    end else if (bus.wb_adr_o == 3'd2) begin
                        bus.wb_dat_i = (fifo.size() != 0) ? fifo.pop_front() : 8'h00;
                    end else begin
                        bus.wb_dat_i = 8'h00;
                    end
                end
            end
            if (!bus.wb_cyc_o && sup_seen) begin
                suppress_once = 1'b0;
                sup_seen = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cyc_n++;
        if (!rst) begin
            if (bus.rx_valid && bus.rx_ready) rx_q.push_back(bus.rx_data);
            if (bus.done) done_cnt++;
            if (bus.err) begin
                err_cnt++;
                err_t = cyc_n;
            end
            if (bus.done && bus.busy) overlap_bad++;
            if (bus.wb_cyc_o && bus.wb_adr_o == 3'd4 && bus.wb_we_o &&
                bus.wb_dat_o == 8'h01 && sson_t < 0) sson_t = cyc_n;
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
        checkOutput({tag, "_cyc"},       int'(bus.wb_cyc_o), 0);
        checkOutput({tag, "_stb"},       int'(bus.wb_stb_o), 0);
        checkOutput({tag, "_busy"},      int'(bus.busy), 0);
        checkOutput({tag, "_done"},      int'(bus.done), 0);
        checkOutput({tag, "_err"},       int'(bus.err), 0);
        checkOutput({tag, "_rx_valid"},  int'(bus.rx_valid), 0);
    endtask

    task automatic feedTx(input logic [7:0] base, input int n);
        bit got;
        for (int i = 0; i < n && !stop_feed; i++) begin
            bus.tx_data  = base + 8'(i);
            bus.tx_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 3000 && !got && !stop_feed; k++) begin
                @(negedge clk);
                if (bus.tx_ready) got = 1'b1;
            end
            if (got) begin
                @(posedge clk);
                #1;
            end
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic waitDone();
        for (int k = 0; k < 20000 && done_cnt == 0 && err_cnt == 0; k++) @(negedge clk);
        stop_feed = 1'b1;
    endtask

    task automatic rxControl(input vec_t v);
        bit seen;
        int bad;
        logic [7:0] first;
        if (v.stall > 0) begin
            seen = 1'b0;
            for (int k = 0; k < 500 && !seen; k++) begin
                @(negedge clk);
                if (bus.rx_valid) seen = 1'b1;
            end
            checkOutput("stall_rx_valid_seen", int'(seen), 1);
            first = bus.rx_data;
            checkOutput("stall_first_rx_data", int'(first), int'(v.base));
            bad = 0;
            for (int c = 0; c < v.stall; c++) begin
                @(negedge clk);
                if (!bus.rx_valid || bus.rx_data != first || bus.wb_cyc_o || bus.wb_stb_o) bad++;
            end
            checkOutput("stall_stable_cycles_bad", bad, 0);
            @(posedge clk);
            #1;
            bus.rx_ready = 1'b1;
        end
    endtask

    task automatic startCmd(input logic [7:0] len, input logic [1:0] mode, input logic [3:0] div);
        @(posedge clk);
        #1;
        bus.cmd_len   = len;
        bus.cmd_mode  = mode;
        bus.cmd_div   = div;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        checkOutput("cmd_ready_before_accept", int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic clearLogs();
        rx_q.delete();
        wr_log.delete();
        spdr_writes = 0;
        done_cnt = 0;
        err_cnt = 0;
        stop_feed = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        clearLogs();
        bus.rx_ready = (v.stall == 0);
        startCmd(v.len, v.mode, v.div);
        @(negedge clk);
        checkOutput("busy_after_accept", int'(bus.busy), 1);
        checkOutput("cmd_ready_in_burst", int'(bus.cmd_ready), 0);
        fork
            feedTx(v.base, int'(v.len) + 1);
            waitDone();
            rxControl(v);
        join
        repeat (3) @(negedge clk);
    endtask

    task automatic verifyBurst(input vec_t v);
        int n;
        int got;
        logic [7:0] eb;
        n = int'(v.len) + 1;
        checkOutput("write_log_size", wr_log.size(), 2 * n + 4);
        for (int i = 0; i < 2 * n + 4; i++) begin
            int exp;
            if (i == 0)                exp = ent(0, int'(v.exp_spcr));
            else if (i == 1)           exp = ent(3, int'(v.exp_sper));
            else if (i == 2)           exp = ent(4, 8'h01);
            else if (i == 2 * n + 3)   exp = ent(4, 8'h00);
            else if ((i - 3) % 2 == 0) begin
                eb = v.base + 8'((i - 3) / 2);
                exp = ent(2, int'(eb));
            end
            else                       exp = ent(1, 8'h80);
            got = (i < wr_log.size()) ? int'(wr_log[i]) : -1;
            checkOutput($sformatf("write_%0d", i), got, exp);
        end
        checkOutput("spdr_write_count", spdr_writes, n);
        checkOutput("rx_byte_count", rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            eb = v.base + 8'(i);
            got = (i < rx_q.size()) ? int'(rx_q[i]) : -1;
            checkOutput($sformatf("rx_byte_%0d", i), got, int'(eb));
        end
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("err_pulses", err_cnt, 0);
        checkOutput("idle_after_burst", int'(bus.cmd_ready), 1);
    endtask

    task automatic resetInPoll();
        bit found;
        clearLogs();
        bus.rx_ready = 1'b1;
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        startCmd(8'h00, 2'd0, 4'h0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (bus.wb_cyc_o && bus.wb_adr_o == 3'd1 && !bus.wb_we_o) found = 1'b1;
        end
        checkOutput("poll_reached", int'(found), 1);
        rst = 1'b1;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_poll_cyc", int'(bus.wb_cyc_o), 0);
        checkOutput("rst_poll_stb", int'(bus.wb_stb_o), 0);
        checkOutput("rst_poll_cmd_ready", int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
    task automatic ackTimeout();
        bit idle;
        clearLogs();
        sson_t = -1;
        suppress_once = 1'b1;
        bus.rx_ready = 1'b1;
        startCmd(8'h00, 2'd0, 4'h0);
        for (int k = 0; k < 200 && err_cnt == 0; k++) @(negedge clk);
        checkOutput("timeout_err_pulses", err_cnt, 1);
        checkOutput("timeout_err_delay", err_t - sson_t, 16);
        idle = 1'b0;
        for (int k = 0; k < 50 && !idle; k++) begin
            @(negedge clk);
            if (bus.cmd_ready) idle = 1'b1;
        end
        checkOutput("timeout_back_to_idle", int'(idle), 1);
        checkOutput("timeout_done_pulses", done_cnt, 0);
        checkOutput("timeout_log_size", wr_log.size(), 3);
        checkOutput("timeout_write_0", (wr_log.size() > 0) ? int'(wr_log[0]) : -1, ent(0, 8'h50));
        checkOutput("timeout_write_1", (wr_log.size() > 1) ? int'(wr_log[1]) : -1, ent(3, 8'h00));
        checkOutput("timeout_write_2", (wr_log.size() > 2) ? int'(wr_log[2]) : -1, ent(4, 8'h00));
    endtask
`endif

    initial begin
        #900000;
        $display("[TB] FAIL global_timeout: simulation still running, required $finish");
        $fatal(1, "[TB] global time limit reached");
    end

    initial begin
        vecs[0] = '{8'h00, 2'd0, 4'h0, 8'hA5,   0, 8'h50, 8'h00};
        vecs[1] = '{8'h00, 2'd3, 4'hF, 8'h3C,   0, 8'h5F, 8'h03};
        vecs[2] = '{8'h02, 2'd1, 4'h6, 8'h10, 100, 8'h56, 8'h01};
        vecs[3] = '{8'h01, 2'd2, 4'h9, 8'hF0,   0, 8'h59, 8'h02};
        vecs[4] = '{8'hFF, 2'd0, 4'h0, 8'h00,   0, 8'h50, 8'h00};

        bus.cmd_valid = 1'b0;
        bus.cmd_len   = 8'h00;
        bus.cmd_mode  = 2'd0;
        bus.cmd_div   = 4'h0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        bus.rx_ready  = 1'b1;
        bus.wb_dat_i  = 8'h00;
        bus.wb_ack_i  = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset_tx_ready", int'(bus.tx_ready), 0);
        checkOutput("reset_rx_data", int'(bus.rx_data), 0);
        checkOutput("reset_we", int'(bus.wb_we_o), 0);
        checkOutput("reset_adr", int'(bus.wb_adr_o), 0);
        checkOutput("reset_dat", int'(bus.wb_dat_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            $display("[TB] burst %0d: len=0x%0h mode=%0d div=0x%0h", v, vecs[v].len, vecs[v].mode, vecs[v].div);
            applyStimulus(vecs[v]);
            verifyBurst(vecs[v]);
        end

        resetInPoll();
        checkIdleOutputs("after_rst");
        applyStimulus(vecs[0]);
        verifyBurst(vecs[0]);

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
        ackTimeout();
`endif

        checkOutput("done_with_busy_overlap", overlap_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
